// File: rtl/spare_bist_bank.sv
// spare_bist_bank: bank of NUM_CH x WIDTH ECO spare flops kept alive by an
// XOR-reduced observe output, with an on-demand LFSR self-test that loads,
// reads back and reports pass/fail for every spare flop.
// Optional build macro SPARE_FAULT_INJECT_EN adds inj_en/inj_ch ports that
// invert bit 0 of one channel during a reload, to prove the checker works.
module spare_bist_bank #(
    parameter int              WIDTH      = 8,
    parameter int              NUM_CH     = 4,
    parameter int              RUN_CYCLES = 16,
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(8'h01),
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(8'hB8)
) (
    input  logic clk,
    input  logic resetn,
    input  logic bist_start,
    output logic bist_busy,
    output logic bist_done,
    output logic bist_pass,
    output logic spare_obs
`ifdef SPARE_FAULT_INJECT_EN
    ,
    input  logic inj_en,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] inj_ch
`endif
);

    localparam int CW = $clog2(RUN_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t                         r_state, w_state_nxt;
    logic [WIDTH-1:0]               r_lfsr;
    logic [WIDTH-1:0]               w_lfsr_nxt;
    logic [WIDTH-1:0]               r_exp;
    logic [NUM_CH-1:0][WIDTH-1:0]   r_ch;
    logic [CW-1:0]                  r_cnt;
    logic                           r_fail;
    logic                           r_pass;
    logic                           r_obs;
    logic                           w_start;
    logic                           w_reload;
    logic                           w_cmp;
    logic [NUM_CH-1:0]              w_miss;
    logic [NUM_CH-1:0]              w_inj;

    assign w_lfsr_nxt = {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};
    assign bist_pass  = r_pass;
    assign spare_obs  = r_obs;

    // Per-channel fault-inject select; only the addressed in-range channel is hit
    always_comb begin
        w_inj = '0;
`ifdef SPARE_FAULT_INJECT_EN
        for (int i = 0; i < NUM_CH; i++)
            w_inj[i] = inj_en && (int'(inj_ch) == i);
`endif
    end

    // Readback compare: each channel should hold exp ^ its index
    always_comb begin
        w_miss = '0;
        for (int i = 0; i < NUM_CH; i++)
            w_miss[i] = (r_ch[i] != (r_exp ^ WIDTH'(i)));
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // FSM next-state and control strobes
    always_comb begin
        w_state_nxt = r_state;
        bist_busy   = 1'b0;
        bist_done   = 1'b0;
        w_start     = 1'b0;
        w_reload    = 1'b0;
        w_cmp       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bist_start) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                bist_busy   = 1'b1;
                w_reload    = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                bist_busy = 1'b1;
                w_reload  = 1'b1;
                w_cmp     = 1'b1;
                if (r_cnt == CW'(RUN_CYCLES - 1)) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                bist_done   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Test datapath: LFSR, expected pattern, sticky fail, cycle count, result
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_lfsr <= SEED;
            r_exp  <= '0;
            r_fail <= 1'b0;
            r_cnt  <= '0;
            r_pass <= 1'b0;
        end else begin
            if (w_start) begin
                r_lfsr <= SEED;
                r_fail <= 1'b0;
                r_cnt  <= '0;
                r_pass <= 1'b0;
            end
            if (w_reload) begin
                r_exp  <= r_lfsr;
                r_lfsr <= w_lfsr_nxt;
            end
            if (w_cmp) begin
                if (|w_miss) r_fail <= 1'b1;
                r_cnt <= r_cnt + CW'(1);
            end
            if (bist_done) r_pass <= ~r_fail;
        end
    end

    // Spare channel registers: written only on LOAD/RUN reloads, else held
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ch <= '0;
        end else if (w_reload) begin
            for (int i = 0; i < NUM_CH; i++)
                r_ch[i] <= (r_lfsr ^ WIDTH'(i)) ^ {{(WIDTH-1){1'b0}}, w_inj[i]};
        end
    end

    // Registered XOR of every spare flop keeps them all observable
    always_ff @(posedge clk) begin
        if (!resetn) r_obs <= 1'b0;
        else         r_obs <= ^r_ch;
    end

endmodule
